// File: rtl/credit_stream_sender.sv
// Transmit side of a credit-based link. It registers each upstream beat onto the link
// and sends only while it holds receiver credits.
module credit_stream_sender #(
    parameter type         T          = logic,
    parameter int unsigned NumCredits = 2,
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    input  logic [$bits(T)-1:0] src_data_i,
    output logic                link_valid_o,
    output logic [$bits(T)-1:0] link_data_o,
    input  logic                credit_i,
    output logic [CntWidth-1:0] credits_o,
    output logic                credit_err_o
);

    localparam int unsigned DataWidth = $bits(T);
    localparam logic [CntWidth-1:0] MaxCredits = CntWidth'(NumCredits);

    logic [CntWidth-1:0]  credit_q, credit_d;
    logic                 link_valid_q, link_valid_d;
    logic [DataWidth-1:0] link_data_q, link_data_d;
    logic                 credit_err_q, credit_err_d;
    logic                 send;

    // Ready comes from the credit flop only, so credit_i never reaches upstream combinationally.
    assign src_ready_o = (credit_q != '0);
    assign send        = src_valid_i && src_ready_o;

    always_comb begin
        credit_d     = credit_q;
        link_valid_d = send;
        link_data_d  = link_data_q;
        credit_err_d = credit_err_q;

        if (send) begin
            link_data_d = src_data_i;
        end

        if (send && !credit_i) begin
            credit_d = credit_q - CntWidth'(1);
        end else if (!send && credit_i) begin
            if (credit_q == MaxCredits) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q     <= MaxCredits;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign link_valid_o = link_valid_q;
    assign link_data_o  = link_data_q;
    assign credits_o    = credit_q;
    assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_credit_stream_sender.sv
// Directed vector bench for credit_stream_sender with NumCredits=2 and an 8-bit payload.
module tb_credit_stream_sender;

    logic       clk;
    logic       rst_ni;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] src_data;
    logic       link_valid;
    logic [7:0] link_data;
    logic       credit;
    logic [1:0] credits;
    logic       credit_err;

    int checks = 0;
    int fails  = 0;

    credit_stream_sender #(
        .T          (logic [7:0]),
        .NumCredits (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .src_valid_i  (src_valid),
        .src_ready_o  (src_ready),
        .src_data_i   (src_data),
        .link_valid_o (link_valid),
        .link_data_o  (link_data),
        .credit_i     (credit),
        .credits_o    (credits),
        .credit_err_o (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       rdy;
        logic       lv;
        logic [7:0] ld;
        logic [1:0] cr;
        logic       err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic lv,
                           input logic [7:0] ld, input logic [1:0] cr, input logic err);
        chk({tag, " src_ready"}, 32'(src_ready), 32'(rdy));
        chk({tag, " link_valid"}, 32'(link_valid), 32'(lv));
        chk({tag, " link_data"}, 32'(link_data), 32'(ld));
        chk({tag, " credits"}, 32'(credits), 32'(cr));
        chk({tag, " credit_err"}, 32'(credit_err), 32'(err));
    endtask

    initial begin
        // Outputs expected after the clock edge that follows each input set.
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b0};
        vecs[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA2, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'hA2, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 8'hA2, 2'd1, 1'b0};
        vecs[4]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA3, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA3, 2'd1, 1'b0};
        vecs[6]  = '{1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 8'hB0, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB0, 2'd2, 1'b0};
        vecs[8]  = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 8'hB1, 2'd2, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd2, 1'b1};
        vecs[10] = '{1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 8'hC1, 2'd1, 1'b1};
        vecs[11] = '{1'b1, 8'hC2, 1'b1, 1'b1, 1'b1, 8'hC2, 2'd1, 1'b1};
        vecs[12] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 2'd0, 1'b1};

        rst_ni    = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        credit    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk_all("reset", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0);

        for (int i = 0; i < 13; i++) begin
            src_valid = vecs[i].v;
            src_data  = vecs[i].d;
            credit    = vecs[i].c;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].lv, vecs[i].ld,
                    vecs[i].cr, vecs[i].err);
        end

        // Mid-operation reset: credits at 0, beat on the link, sticky error set.
        src_valid = 1'b0;
        credit    = 1'b0;
        rst_ni    = 1'b0;
        #1;
        chk_all("async_rst", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 1'b1, 1'b0, 8'h00, 2'd2, 1'b0);

        // The first cycle after release may already send.
        src_valid = 1'b1;
        src_data  = 8'hD1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        chk_all("first_send", 1'b1, 1'b1, 8'hD1, 2'd1, 1'b0);
        @(posedge clk);
        #1;
        chk_all("idle_hold", 1'b1, 1'b0, 8'hD1, 2'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
